// File: rtl/icache_axi_pkg.sv
// Shared types and constants for the I-cache line refill engine.
package icache_axi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [1:0] RRESP_OKAY   = 2'b00;
   localparam logic [2:0] ARPROT_INSTR = 3'b100;
   localparam logic [3:0] ARCACHE_NORM = 4'b0110;

   // Number of byte-address bits that select a byte within one line.
   function automatic int unsigned line_off_w(input int unsigned n_word);
      return $clog2(n_word) + 2;
   endfunction

endpackage

// File: rtl/icache_line_refill_if.sv
// AXI read-channel (AR + R) bundle between the refill engine and instruction memory.
interface icache_line_refill_if #(
   parameter int unsigned WIDTH_ADD = 32,
   parameter int unsigned DATA      = 32
);
   logic                 AXI_ARVALID;
   logic                 AXI_ARREADY;
   logic [WIDTH_ADD-1:0] AXI_ARADDR;
   logic [2:0]           AXI_ARPROT;
   logic [3:0]           AXI_ARCACHE;
   logic                 AXI_RVALID;
   logic [DATA-1:0]      AXI_RDATA;
   logic [1:0]           AXI_RRESP;
   logic                 AXI_RREADY;

   modport master (
      output AXI_ARVALID, AXI_ARADDR, AXI_ARPROT, AXI_ARCACHE, AXI_RREADY,
      input  AXI_ARREADY, AXI_RVALID, AXI_RDATA, AXI_RRESP
   );

   modport slave (
      input  AXI_ARVALID, AXI_ARADDR, AXI_ARPROT, AXI_ARCACHE, AXI_RREADY,
      output AXI_ARREADY, AXI_RVALID, AXI_RDATA, AXI_RRESP
   );
endinterface

// File: rtl/icache_line_assembler.sv
// Line buffer: N_WORD x DATA register file, one indexed word write per beat, flat line output.
module icache_line_assembler #(
   parameter int unsigned DATA   = 32,
   parameter int unsigned N_WORD = 8
) (
   input  logic                       AXI_CLK,
   input  logic                       AXI_RESETn,
   input  logic                       wr_en,
   input  logic [$clog2(N_WORD)-1:0]  wr_idx,
   input  logic [DATA-1:0]            wr_data,
   output logic [DATA*N_WORD-1:0]     line_data
);

   logic [DATA-1:0] words [N_WORD];

   // Store each returned beat into its slot; contents persist until overwritten.
   always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
      if (!AXI_RESETn) begin
         for (int i = 0; i < int'(N_WORD); i++) words[i] <= '0;
      end else if (wr_en) begin
         words[wr_idx] <= wr_data;
      end
   end

   // Flatten the register file; word i lands at [DATA*i +: DATA].
   always_comb begin
      line_data = '0;
      for (int i = 0; i < int'(N_WORD); i++) line_data[DATA*i +: DATA] = words[i];
   end

endmodule

// File: rtl/icache_line_refill.sv
// I-cache miss refill engine: fetches one line as N_WORD single-beat AXI reads.
module icache_line_refill
   import icache_axi_pkg::*;
#(
   parameter int unsigned WIDTH_ADD = 32,
   parameter int unsigned DATA      = 32,
   parameter int unsigned N_WORD    = 8
) (
   input  logic                    AXI_CLK,
   input  logic                    AXI_RESETn,
   input  logic                    miss_req,
   input  logic [WIDTH_ADD-1:0]    miss_addr,
   output logic                    miss_ready,
   output logic [DATA*N_WORD-1:0]  line_data,
   output logic                    line_valid,
   output logic                    line_err,
   icache_line_refill_if.master    axi
);

   localparam int unsigned IW = $clog2(N_WORD);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned OW = line_off_w(N_WORD);
   localparam logic [WIDTH_ADD-1:0] OFF_MASK = (WIDTH_ADD'(1) << OW) - WIDTH_ADD'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(N_WORD);

   state_e               state;
   logic [WIDTH_ADD-1:0] base;
   logic [CW-1:0]        ar_cnt;
   logic [CW-1:0]        r_cnt;
   logic                 err;

   logic                 ar_hs;
   logic                 r_hs;
   logic                 beat_err;
   logic [CW-1:0]        ar_cnt_inc;
   logic [CW-1:0]        r_cnt_inc;
   logic [WIDTH_ADD-1:0] miss_base;

   // Handshake decode and next counter values.
   assign ar_hs      = axi.AXI_ARVALID & axi.AXI_ARREADY;
   assign r_hs       = axi.AXI_RVALID & axi.AXI_RREADY;
   assign beat_err   = axi.AXI_RRESP != RRESP_OKAY;
   assign ar_cnt_inc = ar_cnt + CW'(1);
   assign r_cnt_inc  = r_cnt + CW'(1);
   assign miss_base  = miss_addr & ~OFF_MASK;

   assign miss_ready     = (state == IDLE);
   assign axi.AXI_ARPROT = ARPROT_INSTR;

   // Refill FSM with counters and registered AXI / line outputs.
   always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
      if (!AXI_RESETn) begin
         state           <= IDLE;
         base            <= '0;
         ar_cnt          <= '0;
         r_cnt           <= '0;
         err             <= 1'b0;
         line_valid      <= 1'b0;
         line_err        <= 1'b0;
         axi.AXI_ARVALID <= 1'b0;
         axi.AXI_ARADDR  <= '0;
         axi.AXI_ARCACHE <= '0;
         axi.AXI_RREADY  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               line_valid <= 1'b0;
               line_err   <= 1'b0;
               if (miss_req) begin
                  state           <= FETCH;
                  base            <= miss_base;
                  ar_cnt          <= '0;
                  r_cnt           <= '0;
                  err             <= 1'b0;
                  axi.AXI_ARVALID <= 1'b1;
                  axi.AXI_ARADDR  <= miss_base;
                  axi.AXI_ARCACHE <= ARCACHE_NORM;
                  axi.AXI_RREADY  <= 1'b1;
               end
            end
            FETCH: begin
               // Address side: advance on each accepted AR, stop after the last one.
               if (ar_hs) begin
                  ar_cnt <= ar_cnt_inc;
                  if (ar_cnt_inc >= CNT_FULL) begin
                     axi.AXI_ARVALID <= 1'b0;
                     axi.AXI_ARCACHE <= '0;
                  end else begin
                     axi.AXI_ARADDR <= base + WIDTH_ADD'({ar_cnt_inc, 2'b00});
                  end
               end
               // Data side: count beats, accumulate error, finish on the last beat.
               if (r_hs) begin
                  r_cnt <= r_cnt_inc;
                  err   <= err | beat_err;
                  if (r_cnt_inc >= CNT_FULL) begin
                     state           <= DONE;
                     axi.AXI_RREADY  <= 1'b0;
                     axi.AXI_ARVALID <= 1'b0;
                     axi.AXI_ARCACHE <= '0;
                     line_valid      <= 1'b1;
                     line_err        <= err | beat_err;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               line_valid <= 1'b0;
               line_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   icache_line_assembler #(
      .DATA   (DATA),
      .N_WORD (N_WORD)
   ) u_assembler (
      .AXI_CLK    (AXI_CLK),
      .AXI_RESETn (AXI_RESETn),
      .wr_en      (r_hs),
      .wr_idx     (r_cnt[IW-1:0]),
      .wr_data    (axi.AXI_RDATA),
      .line_data  (line_data)
   );

endmodule

// File: tb/tb_icache_line_refill.sv
// Self-checking bench for icache_line_refill: behavioural AXI slave plus line-level reference model.
module tb_icache_line_refill;
   import icache_axi_pkg::*;

   localparam int unsigned WA = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NW = 8;

   logic AXI_CLK    = 1'b0;
   logic AXI_RESETn = 1'b0;
   always #5 AXI_CLK = ~AXI_CLK;

   logic              miss_req  = 1'b0;
   logic [WA-1:0]     miss_addr = '0;
   logic              miss_ready;
   logic [DW*NW-1:0]  line_data;
   logic              line_valid;
   logic              line_err;

   icache_line_refill_if #(.WIDTH_ADD(WA), .DATA(DW)) axi ();

   icache_line_refill #(.WIDTH_ADD(WA), .DATA(DW), .N_WORD(NW)) dut (
      .AXI_CLK    (AXI_CLK),
      .AXI_RESETn (AXI_RESETn),
      .miss_req   (miss_req),
      .miss_addr  (miss_addr),
      .miss_ready (miss_ready),
      .line_data  (line_data),
      .line_valid (line_valid),
      .line_err   (line_err),
      .axi        (axi)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Slave configuration and observation logs
   int          mode         = 0;   // 0 zero-wait, 1 RVALID every other cycle, 2 random
   int          stall_beat   = -1;
   int          stall_cycles = 0;
   int          err_beat     = -1;
   bit          spurious     = 0;
   bit          gap_phase    = 0;
   logic [31:0] key          = 32'h0;
   logic [31:0] pend_q[$];
   logic [31:0] ar_log[$];
   int          r_idx = 0, ar_seen = 0, stall_done = 0;
   int          stall_obs = 0, stall_bad = 0, spur_used = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_addr;
   logic [3:0]  prev_cache;

   // Instruction memory contents: a keyed hash of the byte address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ key;
   endfunction

   // Reference line: the aligned line containing addr, word i from base + 4*i.
   function automatic logic [DW*NW-1:0] exp_line(input logic [31:0] addr);
      logic [DW*NW-1:0] l;
      logic [31:0] b;
      b = addr & ~32'h1F;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_word(b + 32'(4 * i));
      return l;
   endfunction

   // Behavioural AXI read slave: in-order queue of accepted addresses.
   initial begin
      bit rv_ok;
      axi.AXI_ARREADY = 1'b0;
      axi.AXI_RVALID  = 1'b0;
      axi.AXI_RDATA   = '0;
      axi.AXI_RRESP   = 2'b00;
      forever begin
         @(negedge AXI_CLK);
         if (!AXI_RESETn) begin
            pend_q.delete();
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               stall_obs++;
               if (!(axi.AXI_ARVALID && axi.AXI_ARADDR == prev_addr && axi.AXI_ARCACHE == prev_cache))
                  stall_bad++;
            end
            prev_stall = axi.AXI_ARVALID && !axi.AXI_ARREADY;
            prev_addr  = axi.AXI_ARADDR;
            prev_cache = axi.AXI_ARCACHE;
            if (axi.AXI_ARVALID && !axi.AXI_ARREADY && ar_seen == stall_beat) stall_done++;
            if (axi.AXI_RVALID && axi.AXI_RREADY) begin
               if (pend_q.size() == 0) spur_used++;
               else begin
                  void'(pend_q.pop_front());
                  r_idx++;
               end
            end
            if (axi.AXI_ARVALID && axi.AXI_ARREADY) begin
               pend_q.push_back(axi.AXI_ARADDR);
               ar_log.push_back(axi.AXI_ARADDR);
               ar_seen++;
            end
         end
         @(posedge AXI_CLK);
         #1;
         if (!AXI_RESETn) begin
            axi.AXI_ARREADY = 1'b0;
            axi.AXI_RVALID  = 1'b0;
            axi.AXI_RRESP   = 2'b00;
         end else begin
            if (ar_seen == stall_beat && stall_done < stall_cycles) axi.AXI_ARREADY = 1'b0;
            else if (mode == 2) axi.AXI_ARREADY = 1'($urandom_range(0, 1));
            else axi.AXI_ARREADY = 1'b1;
            gap_phase = ~gap_phase;
            rv_ok = (mode == 0) ? 1'b1 : (mode == 1) ? gap_phase : 1'($urandom_range(0, 1));
            if (pend_q.size() != 0 && rv_ok) begin
               axi.AXI_RVALID = 1'b1;
               axi.AXI_RDATA  = mem_word(pend_q[0]);
               axi.AXI_RRESP  = (r_idx == err_beat) ? 2'b10 : 2'b00;
            end else if (spurious && miss_ready) begin
               axi.AXI_RVALID = 1'b1;
               axi.AXI_RDATA  = 32'hDEAD_BEEF;
               axi.AXI_RRESP  = 2'b00;
            end else begin
               axi.AXI_RVALID = 1'b0;
               axi.AXI_RDATA  = $urandom;
               axi.AXI_RRESP  = 2'b00;
            end
         end
      end
   end

   // One complete refill; cyc counts the accept cycle as cycle 0.
   task automatic run_refill(input logic [31:0] addr, input bit hold, output int cyc,
                             output logic [DW*NW-1:0] line, output logic err, output bit ok);
      bit acc;
      ok = 0; acc = 0; cyc = -1; line = '0; err = 1'b0;
      @(posedge AXI_CLK);
      #2;
      ar_log.delete();
      r_idx = 0; ar_seen = 0; stall_done = 0; stall_obs = 0; stall_bad = 0; spur_used = 0;
      miss_addr = addr;
      miss_req  = 1'b1;
      for (int w = 0; w < 50; w++) begin
         @(negedge AXI_CLK);
         if (miss_ready) begin acc = 1; break; end
      end
      if (acc) begin
         @(posedge AXI_CLK);
         #1;
         if (!hold) miss_req = 1'b0;
         for (int k = 0; k < 400; k++) begin
            @(negedge AXI_CLK);
            if (line_valid) begin
               cyc = k + 1; line = line_data; err = line_err; ok = 1;
               break;
            end
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge AXI_CLK);
      #1;
      n_chk++; if (axi.AXI_ARVALID !== 1'b0) $display("FAIL reset_arvalid got %b want 0", axi.AXI_ARVALID); else n_pass++;
      n_chk++; if (axi.AXI_RREADY !== 1'b0) $display("FAIL reset_rready got %b want 0", axi.AXI_RREADY); else n_pass++;
      n_chk++; if (axi.AXI_ARPROT !== 3'b100) $display("FAIL reset_arprot got %b want 100", axi.AXI_ARPROT); else n_pass++;
      n_chk++; if ({axi.AXI_ARADDR, axi.AXI_ARCACHE} !== 36'h0) $display("FAIL reset_araddr_cache got %h want 0", {axi.AXI_ARADDR, axi.AXI_ARCACHE}); else n_pass++;
      n_chk++; if ({miss_ready, line_valid, line_err} !== 3'b100) $display("FAIL reset_status got %b want 100", {miss_ready, line_valid, line_err}); else n_pass++;
      n_chk++; if (line_data !== '0) $display("FAIL reset_line got %h want 0", line_data); else n_pass++;
      @(negedge AXI_CLK);
      AXI_RESETn = 1'b1;
   endtask

   task automatic test_basic;
      int cyc; logic [DW*NW-1:0] line, exp; logic err; bit ok;
      mode = 0; err_beat = -1;
      exp = exp_line(32'h0000_1234);
      run_refill(32'h0000_1234, 0, cyc, line, err, ok);
      n_chk++; if (!ok) $display("FAIL basic_timeout got no line_valid want line_valid"); else n_pass++;
      n_chk++; if (cyc !== 10) $display("FAIL basic_latency got %0d want 10", cyc); else n_pass++;
      n_chk++; if (ar_log.size() !== 8) $display("FAIL basic_ar_count got %0d want 8", ar_log.size()); else n_pass++;
      for (int i = 0; i < ar_log.size() && i < 8; i++) begin
         n_chk++; if (ar_log[i] !== 32'h1220 + 32'(4 * i)) $display("FAIL basic_araddr[%0d] got %h want %h", i, ar_log[i], 32'h1220 + 32'(4 * i)); else n_pass++;
      end
      n_chk++; if (line !== exp) $display("FAIL basic_line got %h want %h", line, exp); else n_pass++;
      n_chk++; if (err !== 1'b0) $display("FAIL basic_err got %b want 0", err); else n_pass++;
      @(negedge AXI_CLK);
      n_chk++; if (line_valid !== 1'b0) $display("FAIL basic_pulse got %b want 0", line_valid); else n_pass++;
      n_chk++; if (line_data !== exp) $display("FAIL basic_hold got %h want %h", line_data, exp); else n_pass++;
   endtask

   task automatic test_ar_stall;
      int cyc; logic [DW*NW-1:0] line, exp; logic err; bit ok; logic [31:0] a, b;
      mode = 0; stall_beat = 2; stall_cycles = 3;
      a = $urandom; b = a & ~32'h1F; exp = exp_line(a);
      run_refill(a, 0, cyc, line, err, ok);
      n_chk++; if (!ok) $display("FAIL stall_timeout got no line_valid want line_valid"); else n_pass++;
      n_chk++; if (stall_obs !== 3) $display("FAIL stall_cycles got %0d want 3", stall_obs); else n_pass++;
      n_chk++; if (stall_bad !== 0) $display("FAIL stall_stable got %0d changes want 0", stall_bad); else n_pass++;
      n_chk++; if (cyc !== 13) $display("FAIL stall_latency got %0d want 13", cyc); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_chk++; if (i >= ar_log.size() || ar_log[i] !== b + 32'(4 * i)) $display("FAIL stall_araddr[%0d] got %h want %h", i, (i < ar_log.size()) ? ar_log[i] : 32'hX, b + 32'(4 * i)); else n_pass++;
      end
      n_chk++; if (line !== exp) $display("FAIL stall_line got %h want %h", line, exp); else n_pass++;
      stall_beat = -1; stall_cycles = 0;
   endtask

   task automatic test_err;
      int cyc; logic [DW*NW-1:0] line, exp; logic err; bit ok; logic [31:0] a;
      mode = 0; err_beat = 5;
      a = $urandom; exp = exp_line(a);
      run_refill(a, 0, cyc, line, err, ok);
      n_chk++; if (!ok) $display("FAIL err_timeout got no line_valid want line_valid"); else n_pass++;
      n_chk++; if (r_idx !== 8) $display("FAIL err_beats got %0d want 8", r_idx); else n_pass++;
      n_chk++; if (err !== 1'b1) $display("FAIL err_flag got %b want 1", err); else n_pass++;
      n_chk++; if (line !== exp) $display("FAIL err_line got %h want %h", line, exp); else n_pass++;
      @(negedge AXI_CLK);
      n_chk++; if (line_err !== 1'b0) $display("FAIL err_pulse got %b want 0", line_err); else n_pass++;
      err_beat = -1;
      a = $urandom; exp = exp_line(a);
      run_refill(a, 0, cyc, line, err, ok);
      n_chk++; if (!ok || err !== 1'b0) $display("FAIL err_cleared got ok=%0d err=%b want ok=1 err=0", ok, err); else n_pass++;
      n_chk++; if (line !== exp) $display("FAIL err_line2 got %h want %h", line, exp); else n_pass++;
   endtask

   task automatic test_hold_req;
      int cyc; logic [DW*NW-1:0] line, exp; logic err; bit ok, got; logic [31:0] a;
      mode = 0; a = $urandom; exp = exp_line(a);
      run_refill(a, 1, cyc, line, err, ok);
      n_chk++; if (!ok || ar_log.size() !== 8) $display("FAIL hold_single got ok=%0d ars=%0d want ok=1 ars=8", ok, ar_log.size()); else n_pass++;
      n_chk++; if (line !== exp) $display("FAIL hold_line got %h want %h", line, exp); else n_pass++;
      @(negedge AXI_CLK);
      n_chk++; if (miss_ready !== 1'b1) $display("FAIL hold_idle_ready got %b want 1", miss_ready); else n_pass++;
      @(posedge AXI_CLK);
      #1;
      n_chk++; if (miss_ready !== 1'b0) $display("FAIL hold_second_accept got %b want 0", miss_ready); else n_pass++;
      miss_req = 1'b0;
      got = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge AXI_CLK);
         if (line_valid) begin got = 1; break; end
      end
      n_chk++; if (!got || line_data !== exp) $display("FAIL hold_second_line got %h want %h", line_data, exp); else n_pass++;
      n_chk++; if (ar_log.size() !== 16) $display("FAIL hold_second_ars got %0d want 16", ar_log.size()); else n_pass++;
   endtask

   task automatic test_gaps;
      int cyc; logic [DW*NW-1:0] line, exp, prev; logic err; bit ok; int bad; logic [31:0] a;
      prev = line_data;
      mode = 0; spurious = 1; bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge AXI_CLK);
         if (axi.AXI_RVALID && axi.AXI_RREADY) bad++;
      end
      n_chk++; if (bad !== 0) $display("FAIL gaps_idle_rready got %0d consumed want 0", bad); else n_pass++;
      n_chk++; if (line_data !== prev) $display("FAIL gaps_idle_line got %h want %h", line_data, prev); else n_pass++;
      mode = 1; a = $urandom; exp = exp_line(a);
      run_refill(a, 0, cyc, line, err, ok);
      n_chk++; if (!ok) $display("FAIL gaps_timeout got no line_valid want line_valid"); else n_pass++;
      n_chk++; if (line !== exp) $display("FAIL gaps_line got %h want %h", line, exp); else n_pass++;
      n_chk++; if (spur_used !== 0 || r_idx !== 8) $display("FAIL gaps_beats got extra=%0d beats=%0d want extra=0 beats=8", spur_used, r_idx); else n_pass++;
      spurious = 0; mode = 0;
   endtask

   task automatic test_random;
      int cyc; logic [DW*NW-1:0] line, exp; logic err; bit ok; logic [31:0] a, b; int eb; int bad;
      mode = 2;
      for (int t = 0; t < 6; t++) begin
         a = $urandom; b = a & ~32'h1F; exp = exp_line(a);
         eb = int'($urandom_range(0, 15)); err_beat = eb;
         run_refill(a, 0, cyc, line, err, ok);
         bad = 0;
         for (int i = 0; i < 8; i++) if (i >= ar_log.size() || ar_log[i] !== b + 32'(4 * i)) bad++;
         n_chk++; if (!ok || line !== exp) $display("FAIL rand%0d_line got %h want %h", t, line, exp); else n_pass++;
         n_chk++; if (err !== (eb < 8)) $display("FAIL rand%0d_err got %b want %b", t, err, eb < 8); else n_pass++;
         n_chk++; if (bad !== 0 || ar_log.size() !== 8) $display("FAIL rand%0d_araddr got %0d wrong of %0d want 0 of 8", t, bad, ar_log.size()); else n_pass++;
         n_chk++; if (stall_bad !== 0) $display("FAIL rand%0d_stable got %0d changes want 0", t, stall_bad); else n_pass++;
      end
      mode = 0; err_beat = -1;
   endtask

   task automatic test_reset_mid;
      int cyc; logic [DW*NW-1:0] line, exp; logic err; bit ok, got; logic [31:0] a;
      mode = 0;
      @(posedge AXI_CLK);
      #2;
      ar_log.delete(); r_idx = 0; ar_seen = 0;
      miss_addr = $urandom; miss_req = 1'b1;
      got = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge AXI_CLK);
         if (r_idx >= 3) begin got = 1; break; end
         if (!miss_ready) miss_req = 1'b0;
      end
      miss_req = 1'b0;
      n_chk++; if (!got) $display("FAIL rstmid_timeout got %0d beats want 3", r_idx); else n_pass++;
      @(posedge AXI_CLK);
      #3;
      AXI_RESETn = 1'b0;
      #1;
      n_chk++; if ({axi.AXI_ARVALID, axi.AXI_RREADY, line_valid, line_err} !== 4'b0000) $display("FAIL rstmid_ctrl got %b want 0000", {axi.AXI_ARVALID, axi.AXI_RREADY, line_valid, line_err}); else n_pass++;
      n_chk++; if ({axi.AXI_ARADDR, axi.AXI_ARCACHE} !== 36'h0 || axi.AXI_ARPROT !== 3'b100) $display("FAIL rstmid_ar got %h/%b want 0/100", {axi.AXI_ARADDR, axi.AXI_ARCACHE}, axi.AXI_ARPROT); else n_pass++;
      n_chk++; if (miss_ready !== 1'b1 || line_data !== '0) $display("FAIL rstmid_idle got ready=%b line=%h want ready=1 line=0", miss_ready, line_data); else n_pass++;
      @(posedge AXI_CLK);
      #2;
      AXI_RESETn = 1'b1;
      a = $urandom; exp = exp_line(a);
      run_refill(a, 0, cyc, line, err, ok);
      n_chk++; if (!ok || line !== exp) $display("FAIL rstmid_refill got %h want %h", line, exp); else n_pass++;
      n_chk++; if (cyc !== 10 || err !== 1'b0 || ar_log.size() !== 8) $display("FAIL rstmid_clean got cyc=%0d err=%b ars=%0d want 10/0/8", cyc, err, ar_log.size()); else n_pass++;
   endtask

   initial begin
      key = $urandom;
      test_reset;
      test_basic;
      test_ar_stall;
      test_err;
      test_hold_req;
      test_gaps;
      test_random;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
